fft64_out_serializer: RTL and testbench
=======================================

// Module: fft64_out_serializer
// PURPOSE
//  Output stage directly downstream of the 64-point FFT core.
//  - Captures each 64-sample complex frame (one-cycle valid pulse, all samples in parallel) into a ping-pong buffer.
//  - Streams the frame out as NBEATS = 64/LANES beats over a valid/ready interface.
//  - The FFT has no backpressure, so frames arriving with both banks full are dropped and flagged.
// PARAMETERS
//  NBW_IN   13   bit width of each I/Q component (FFT output width); passed through unchanged
//  LANES    8    complex samples per output beat; power of 2, 1..64; elaboration error otherwise
// PORTS
//  clk            in   1                  clock
//  rst_async_n    in   1                  reset, asynchronous, active-low
//  i_valid        in   1                  frame strobe from FFT, one cycle per frame
//  i_data         in   [63:0][1:0]xNBW_IN signed frame, natural order, [n][0]=I, [n][1]=Q
//  i_ready        in   1                  downstream accepts current beat
//  i_ovf_clr      in   1                  clears o_ovf_sticky
//  o_valid        out  1                  beat available
//  o_data         out  [LANES-1:0][1:0]xNBW_IN  beat payload, lane l = sample b*LANES+l
//  o_sof          out  1                  qualifies first beat (b=0) of a frame
//  o_eof          out  1                  qualifies last beat (b=NBEATS-1) of a frame
//  o_overflow     out  1                  one-cycle pulse: incoming frame dropped
//  o_ovf_sticky   out  1                  latched overflow status
// BEHAVIOUR
//  - Reset: o_valid, o_sof, o_eof, o_overflow, o_ovf_sticky = 0; wr_bank = rd_bank = 0; full[1:0] = 0; beat = 0.
//    o_data is don't-care while o_valid = 0.
//  - State: two 64-sample banks, full[1:0], wr_bank, rd_bank, beat counter 0..NBEATS-1.
//  - Write: on i_valid with !full[wr_bank], the whole frame is written to bank wr_bank in one cycle.
//    full[wr_bank] is set and wr_bank toggles.
//  - Read: o_valid = full[rd_bank]; o_data = bank[rd_bank][beat*LANES +: LANES]; all read outputs come from flops.
//  - Latency: frame strobed at edge N -> o_valid = 1 after edge N (first beat in cycle N+1) if the read side is idle.
//  - Handshake:
//    - beat advances only on o_valid && i_ready.
//    - o_data, o_sof, o_eof hold stable while o_valid && !i_ready.
//    - o_valid never drops mid-frame.
//  - End of frame: on accept at beat = NBEATS-1, clear full[rd_bank], toggle rd_bank, and wrap beat to 0.
//    If the other bank is full, its first beat follows back-to-back in the next cycle (no bubble).
//  - LANES = 64: NBEATS = 1, and o_sof = o_eof = 1 on every beat.
//  - Simultaneous write and last-beat accept: both take effect.
//    The write always targets the non-reading bank, so no conflict.
//  - Overflow: i_valid with full[wr_bank] = 1 (both banks full) drops the frame.
//    - Bank contents and pointers are untouched.
//    - o_overflow = 1 for one cycle; o_ovf_sticky is set.
//  - Sticky clear: i_ovf_clr clears o_ovf_sticky; a set in the same cycle wins.
//  - Throughput: sustains one frame per NBEATS cycles with i_ready held high.
//    i_valid spacing below NBEATS cycles eventually overflows by design.
//  - Reset mid-frame: the in-flight frame and both banks are discarded.
//    After reset release, o_valid stays 0 until the next i_valid.
//  - No arithmetic: data passes bit-exact, signedness preserved.
// STRUCTURE
//  - Shared package fe_fft_pkg holds:
//    - NFFT = 64;
//    - I = 0, Q = 1 component indices;
//    - function clog2-safe beat counter width helper.
//  - Sub-module fe_frame_bank: one 64-sample register bank, parallel write-enable, LANES-wide beat read mux.
//    Instantiated twice.
//  - Top level holds the pointers, full flags, beat counter, flag logic and read-side bank select.
// TESTING
//  1. Single frame, LANES=8, i_ready=1, sample n I=n, Q=-n:
//     -> 8 beats in consecutive cycles starting 1 cycle after i_valid.
//     -> beat 3 lane 2 = (26,-26); o_sof on beat 0 only, o_eof on beat 7 only.
//  2. Backpressure: i_ready toggling 1,0,0,1 pattern:
//     -> o_data/o_sof/o_eof stable during stalls; all 64 samples delivered in order, none duplicated.
//  3. Back-to-back frames A, B strobed 8 cycles apart, i_ready=1:
//     -> 16 contiguous beats, A then B, no bubble.
//     -> A's last-beat accept and C's strobe in the same cycle: C captured without loss.
//  4. Overflow: i_ready=0, three frames strobed:
//     -> frames 1 and 2 buffered; frame 3 gives o_overflow pulse, o_ovf_sticky=1.
//     -> releasing i_ready outputs frames 1, 2 intact; i_ovf_clr then clears sticky (not if an overflow coincides).
//  5. Reset asserted at beat 4 of a frame:
//     -> all outputs 0 asynchronously; after release no o_valid until a new i_valid.
//     -> the new frame starts with o_sof at beat 0.
//  6. LANES=64 and LANES=1 builds:
//     -> 1 beat with sof=eof=1, and 64 beats respectively.
//     -> sample ordering checked against a scoreboard.

Source files
------------

// File: rtl/fe_fft_pkg.sv
// Shared constants and helpers for the FFT front-end output path.
// Sample layout: [n][I] / [n][Q] with NFFT samples per frame.
package fe_fft_pkg;

  localparam int NFFT = 64;
  localparam int I = 0;
  localparam int Q = 1;

  function automatic int beat_w(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/fe_frame_bank.sv
// One frame-sized sample register bank.
// Whole frame written in a single cycle, read out one beat at a time.
module fe_frame_bank
  import fe_fft_pkg::*;
#(
  parameter int NBW_IN = 13,
  parameter int LANES  = 8,
  parameter int BW     = 3
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic signed [NFFT-1:0][1:0][NBW_IN-1:0]  wdata,
  input  logic [BW-1:0]                          beat,
  output logic signed [LANES-1:0][1:0][NBW_IN-1:0] rdata
);

  logic signed [NFFT-1:0][1:0][NBW_IN-1:0] mem;

  // Payload only; validity is tracked by the owner's full flags.
  always_ff @(posedge clk) begin
    if (we) begin
      mem <= wdata;
    end
  end

  assign rdata = mem[int'(beat) * LANES +: LANES];

endmodule

// File: rtl/fft64_out_serializer.sv
// Ping-pong frame buffer that streams 64-sample FFT frames
// out as LANES-wide beats over a valid/ready interface.
module fft64_out_serializer
  import fe_fft_pkg::*;
#(
  parameter int NBW_IN = 13,
  parameter int LANES  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_async_n,
  input  logic                                   i_valid,
  input  logic signed [NFFT-1:0][1:0][NBW_IN-1:0]  i_data,
  input  logic                                   i_ready,
  input  logic                                   i_ovf_clr,
  output logic                                   o_valid,
  output logic signed [LANES-1:0][1:0][NBW_IN-1:0] o_data,
  output logic                                   o_sof,
  output logic                                   o_eof,
  output logic                                   o_overflow,
  output logic                                   o_ovf_sticky
);

  localparam int NBEATS = NFFT / LANES;
  localparam int BW     = beat_w(NBEATS);
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

  if ((LANES < 1) || (LANES > NFFT) ||
      ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
    $error("LANES must be a power of 2 in 1..64");
  end

  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic          wr_bank_q;
  logic          rd_bank_q;
  logic [BW-1:0] beat_q;
  logic          ovf_q;
  logic          sticky_q;
  logic          wr_en;
  logic          drop;
  logic          acc;
  logic          last_acc;

  logic signed [LANES-1:0][1:0][NBW_IN-1:0] rd0;
  logic signed [LANES-1:0][1:0][NBW_IN-1:0] rd1;

  assign o_valid  = full_q[rd_bank_q];
  assign acc      = o_valid & i_ready;
  assign last_acc = acc & (beat_q == LAST);
  assign wr_en    = i_valid & ~full_q[wr_bank_q];
  assign drop     = i_valid & full_q[wr_bank_q];

  // A write never lands on the bank being read, so both updates compose.
  always_comb begin
    full_d = full_q;
    if (last_acc) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_en) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      beat_q    <= '0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      ovf_q  <= drop;
      if (wr_en) begin
        wr_bank_q <= ~wr_bank_q;
      end
      if (last_acc) begin
        rd_bank_q <= ~rd_bank_q;
        beat_q    <= '0;
      end else if (acc) begin
        beat_q <= beat_q + 1'b1;
      end
      if (drop) begin
        sticky_q <= 1'b1;
      end else if (i_ovf_clr) begin
        sticky_q <= 1'b0;
      end
    end
  end

  fe_frame_bank #(
    .NBW_IN (NBW_IN),
    .LANES  (LANES),
    .BW     (BW)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_en & ~wr_bank_q),
    .wdata (i_data),
    .beat  (beat_q),
    .rdata (rd0)
  );

  fe_frame_bank #(
    .NBW_IN (NBW_IN),
    .LANES  (LANES),
    .BW     (BW)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_en & wr_bank_q),
    .wdata (i_data),
    .beat  (beat_q),
    .rdata (rd1)
  );

  assign o_data       = rd_bank_q ? rd1 : rd0;
  assign o_sof        = o_valid & (beat_q == '0);
  assign o_eof        = o_valid & (beat_q == LAST);
  assign o_overflow   = ovf_q;
  assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fft64_out_serializer.sv
// Scoreboard bench: LANES=8, 64 and 1 builds share one stimulus
// stream, each checked against a sample-queue reference model.
module tb_fft64_out_serializer;
  import fe_fft_pkg::*;

  localparam int W  = 13;
  localparam int NI = 3;

  typedef logic [NFFT-1:0][2*W-1:0] frame_t;

  function automatic int lanes_of(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 64 : 1);
  endfunction

  logic clk = 1'b0;
  logic rst_async_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  logic i_ovf_clr = 1'b0;
  logic signed [NFFT-1:0][1:0][W-1:0] i_data = '0;

  logic [2*W-1:0] od [NI][NFFT];
  logic ov_v [NI];
  logic ov_sof [NI];
  logic ov_eof [NI];
  logic ov_ovf [NI];
  logic ov_stk [NI];

  frame_t frames[$];
  logic   fin_chk = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LN = lanes_of(g);
    logic signed [LN-1:0][1:0][W-1:0] o_data;
    logic o_valid;
    logic o_sof;
    logic o_eof;
    logic o_overflow;
    logic o_ovf_sticky;

    fft64_out_serializer #(
      .NBW_IN (W),
      .LANES  (LN)
    ) u_dut (
      .clk          (clk),
      .rst_async_n  (rst_async_n),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .i_ready      (i_ready),
      .i_ovf_clr    (i_ovf_clr),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_sof        (o_sof),
      .o_eof        (o_eof),
      .o_overflow   (o_overflow),
      .o_ovf_sticky (o_ovf_sticky)
    );

    for (genvar l = 0; l < NFFT; l++) begin : g_lane
      if (l < LN) begin : g_on
        assign od[g][l] = o_data[l];
      end else begin : g_off
        assign od[g][l] = '0;
      end
    end

    assign ov_v[g]   = o_valid;
    assign ov_sof[g] = o_sof;
    assign ov_eof[g] = o_eof;
    assign ov_ovf[g] = o_overflow;
    assign ov_stk[g] = o_ovf_sticky;
  end

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (LANES=%0d) t=%0t: got %0h, expected %0h",
               nm, lanes_of(g), $time, act, exp);
    end
  endtask

  // Reference model + monitor. Expected samples live in a per-build
  // queue; a frame is dropped when two frames are still outstanding.
  logic [2*W-1:0] exp_q [NI][$];
  logic           ovf_e [NI];
  logic           stk_e [NI];
  int             rd_i = 0;

  always @(negedge clk) begin : mon
    int     sz;
    int     ln;
    int     idx;
    bit     drop;
    bit     newf;
    frame_t f;
    newf = 1'b0;
    f    = '0;
    if (frames.size() > rd_i) begin
      f    = frames[rd_i];
      newf = 1'b1;
      rd_i++;
    end
    for (int g = 0; g < NI; g++) begin
      ln = lanes_of(g);
      sz = exp_q[g].size();
      if (!rst_async_n) begin
        exp_q[g].delete();
        ovf_e[g] = 1'b0;
        stk_e[g] = 1'b0;
        chk("rst_valid", g, 32'(ov_v[g]), 0);
        chk("rst_sof", g, 32'(ov_sof[g]), 0);
        chk("rst_eof", g, 32'(ov_eof[g]), 0);
        chk("rst_ovf", g, 32'(ov_ovf[g]), 0);
        chk("rst_sticky", g, 32'(ov_stk[g]), 0);
      end else begin
        chk("valid", g, 32'(ov_v[g]), 32'(sz > 0));
        chk("overflow", g, 32'(ov_ovf[g]), 32'(ovf_e[g]));
        chk("sticky", g, 32'(ov_stk[g]), 32'(stk_e[g]));
        if (fin_chk) begin
          chk("drained", g, 32'(sz), 0);
        end
        if (sz > 0) begin
          idx = (NFFT - (sz % NFFT)) % NFFT;
          chk("sof", g, 32'(ov_sof[g]), 32'(idx == 0));
          chk("eof", g, 32'(ov_eof[g]), 32'(idx == NFFT - ln));
          for (int l = 0; l < ln; l++) begin
            chk("data", g, 32'(od[g][l]), 32'(exp_q[g][l]));
          end
          if (i_ready) begin
            for (int l = 0; l < ln; l++) begin
              void'(exp_q[g].pop_front());
            end
          end
        end
        drop = i_valid && (((sz + NFFT - 1) / NFFT) >= 2);
        if (newf && !drop) begin
          for (int n = 0; n < NFFT; n++) begin
            exp_q[g].push_back(f[n]);
          end
        end
        stk_e[g] = drop ? 1'b1 : (i_ovf_clr ? 1'b0 : stk_e[g]);
        ovf_e[g] = drop;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input bit ramp, input bit clr);
    logic signed [NFFT-1:0][1:0][W-1:0] d;
    for (int n = 0; n < NFFT; n++) begin
      if (ramp) begin
        d[n][I] = W'(n);
        d[n][Q] = W'(-n);
      end else begin
        d[n] = (2*W)'($urandom);
      end
    end
    i_data    = d;
    frames.push_back(frame_t'(d));
    i_valid   = 1'b1;
    i_ovf_clr = clr;
    cyc(1);
    i_valid   = 1'b0;
    i_ovf_clr = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_async_n = 1'b1;
    cyc(2);

    // single ramp frame, free-flowing sink
    i_ready = 1'b1;
    strobe(1'b1, 1'b0);
    cyc(80);

    // 1,0,0,1 backpressure pattern
    strobe(1'b0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      i_ready = ((k % 4) == 0) || ((k % 4) == 3);
      cyc(1);
    end

    // back-to-back frames 8 cycles apart
    i_ready = 1'b1;
    strobe(1'b0, 1'b0);
    cyc(7);
    strobe(1'b0, 1'b0);
    cyc(7);
    strobe(1'b0, 1'b0);
    cyc(220);

    // overflow with stalled sink; clear racing a set, then alone
    i_ready = 1'b0;
    strobe(1'b0, 1'b0);
    cyc(2);
    strobe(1'b0, 1'b0);
    cyc(2);
    strobe(1'b0, 1'b0);
    cyc(3);
    strobe(1'b0, 1'b1);
    cyc(2);
    i_ovf_clr = 1'b1;
    cyc(1);
    i_ovf_clr = 1'b0;
    cyc(2);
    i_ready = 1'b1;
    cyc(150);

    // reset while beat 4 is presented
    strobe(1'b0, 1'b0);
    cyc(4);
    #2;
    rst_async_n = 1'b0;
    @(posedge clk);
    #1;
    rst_async_n = 1'b1;
    cyc(10);
    strobe(1'b0, 1'b0);
    cyc(80);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      i_ready   = ($urandom_range(0, 3) != 0);
      i_ovf_clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 24) == 0) begin
        strobe(1'b0, i_ovf_clr);
      end else begin
        cyc(1);
      end
    end
    i_ready   = 1'b1;
    i_ovf_clr = 1'b0;
    cyc(200);
    fin_chk = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
